// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Divides clk_100MHz down to a pixel tick and produces pixel coordinates,
// display enable, sync pulses of configurable polarity, line/frame start
// strobes and a run/stop handshake that only changes on frame boundaries.
// Optional feature macro: VTG_FRAME_COUNTER_EN adds a 16-bit frame_count output.

module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int HD        = 640,
    parameter int HF        = 16,
    parameter int HR        = 96,
    parameter int HB        = 48,
    parameter int VD        = 480,
    parameter int VF        = 10,
    parameter int VR        = 2,
    parameter int VB        = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          enable,
    output logic          running,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_FRAME_COUNTER_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    // Raster geometry.
    localparam int HTOT = HD + HF + HR + HB;
    localparam int VTOT = VD + VF + VR + VB;

    // Sync windows and active-area limits, widened to 32 bits so a window
    // ending exactly at 2^CW cannot overflow the coordinate width.
    localparam logic [31:0] H_ACTIVE   = 32'(HD);
    localparam logic [31:0] V_ACTIVE   = 32'(VD);
    localparam logic [31:0] HS_START   = 32'(HD + HF);
    localparam logic [31:0] HS_END     = 32'(HD + HF + HR);
    localparam logic [31:0] VS_START   = 32'(VD + VF);
    localparam logic [31:0] VS_END     = 32'(VD + VF + VR);

    localparam logic [CW-1:0] X_LAST = CW'(HTOT - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(VTOT - 1);

    // Divider width: at least one bit so CLK_DIV=1 still has a legal register.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    // Run/stop states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [DW-1:0] r_divCnt;
    logic [1:0]    r_state;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_videoOn;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_lineStart;
    logic          r_frameStart;

    logic          w_tick;
    logic          w_hWrap;
    logic          w_vWrap;
    logic [CW-1:0] w_xAdv;
    logic [CW-1:0] w_yAdv;
    logic [1:0]    w_stateNext;
    logic [CW-1:0] w_xNext;
    logic [CW-1:0] w_yNext;
    logic          w_lineStrobe;
    logic          w_frameStrobe;
    logic          w_active;
    logic          w_videoNext;
    logic          w_hsActive;
    logic          w_vsActive;

    assign w_tick = (r_divCnt == DIV_LAST);

    // Pixel divider: free-running 0..CLK_DIV-1 in every state.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_divCnt <= '0;
        end else if (w_tick) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // Raster position one pixel ahead, used by RUN and DRAIN alike.
    always_comb begin
        w_hWrap = (r_x == X_LAST);
        w_vWrap = (r_y == Y_LAST);
        w_xAdv  = w_hWrap ? '0 : r_x + 1'b1;
        w_yAdv  = r_y;
        if (w_hWrap) begin
            w_yAdv = w_vWrap ? '0 : r_y + 1'b1;
        end
    end

    // Next state, next coordinates and strobe requests for the coming tick.
    always_comb begin
        w_stateNext   = r_state;
        w_xNext       = r_x;
        w_yNext       = r_y;
        w_lineStrobe  = 1'b0;
        w_frameStrobe = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_xNext = '0;
                    w_yNext = '0;
                    if (enable) begin
                        w_stateNext   = S_RUN;
                        w_lineStrobe  = 1'b1;
                        w_frameStrobe = 1'b1;
                    end
                end
                S_RUN: begin
                    w_xNext       = w_xAdv;
                    w_yNext       = w_yAdv;
                    w_lineStrobe  = w_hWrap;
                    w_frameStrobe = w_hWrap && w_vWrap;
                    if (!enable) begin
                        w_stateNext = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    w_xNext      = w_xAdv;
                    w_yNext      = w_yAdv;
                    w_lineStrobe = w_hWrap;
                    if (w_hWrap && w_vWrap) begin
                        if (enable) begin
                            w_stateNext   = S_RUN;
                            w_frameStrobe = 1'b1;
                        end else begin
                            w_stateNext  = S_IDLE;
                            w_lineStrobe = 1'b0;
                        end
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                    w_xNext     = '0;
                    w_yNext     = '0;
                end
            endcase
        end
    end

    // Display-enable and sync windows decoded from the next-state counts.
    always_comb begin
        w_active    = (w_stateNext != S_IDLE);
        w_videoNext = w_active
                      && (32'(w_xNext) < H_ACTIVE)
                      && (32'(w_yNext) < V_ACTIVE);
        w_hsActive  = w_active
                      && (32'(w_xNext) >= HS_START)
                      && (32'(w_xNext) < HS_END);
        w_vsActive  = w_active
                      && (32'(w_yNext) >= VS_START)
                      && (32'(w_yNext) < VS_END);
    end

    // State, coordinates, syncs and video_on all move together on a tick.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_videoOn <= 1'b0;
            r_hsync   <= ~HSYNC_POL;
            r_vsync   <= ~VSYNC_POL;
        end else if (w_tick) begin
            r_state   <= w_stateNext;
            r_x       <= w_xNext;
            r_y       <= w_yNext;
            r_videoOn <= w_videoNext;
            r_hsync   <= w_hsActive ? HSYNC_POL : ~HSYNC_POL;
            r_vsync   <= w_vsActive ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    // Strobes last exactly one clk_100MHz cycle after the updating edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_lineStart  <= w_tick && w_lineStrobe;
            r_frameStart <= w_tick && w_frameStrobe;
        end
    end

`ifdef VTG_FRAME_COUNTER_EN
    logic [15:0] r_frameCount;

    // Frame counter advances during the frame_start cycle and wraps naturally.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_frameCount <= '0;
        end else if (r_frameStart) begin
            r_frameCount <= r_frameCount + 16'd1;
        end
    end

    assign frame_count = r_frameCount;
`else
    // Without the frame counter there is no extra state to keep.
`endif

    assign running     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign p_tick      = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_videoOn;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen using a
// small 8x5 raster (HTOT=8, VTOT=5) at CLK_DIV=3, hsync active-high,
// vsync active-low. Frame counter checks apply when VTG_FRAME_COUNTER_EN is set.

module tb_vga_timing_gen;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          running;
    logic          p_tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
`ifdef VTG_FRAME_COUNTER_EN
    logic [15:0]   frame_count;
`endif

    int checks   = 0;
    int failures = 0;
    int ex       = 0;
    int ey       = 0;
    int cyc      = 0;
    int frameCycles = 0;
    int videoTicks  = 0;

    vga_timing_gen #(
        .CLK_DIV  (3),
        .HD       (4),
        .HF       (1),
        .HR       (2),
        .HB       (1),
        .VD       (2),
        .VF       (1),
        .VR       (1),
        .VB       (1),
        .HSYNC_POL(1'b1),
        .VSYNC_POL(1'b0),
        .CW       (CW)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .enable     (enable),
        .running    (running),
        .p_tick     (p_tick),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .line_start (line_start),
`ifdef VTG_FRAME_COUNTER_EN
        .frame_count(frame_count),
`endif
        .frame_start(frame_start)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance through the next pixel-tick edge; returns clocks consumed.
    task automatic applyStimulus(output int cycles);
        cycles = 0;
        while (p_tick !== 1'b1 && cycles < 8) begin
            step();
            cycles++;
        end
        checkOutput("tickSeen", 32'(p_tick), 32'd1);
        step();
        cycles++;
    endtask

    // Reference raster position: 8 pixels per line, 5 lines per frame.
    task automatic advanceModel();
        if (ex == 7) begin
            ex = 0;
            ey = (ey == 4) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) step();

        // Reset state.
        checkOutput("rstX",          32'(x),           32'd0);
        checkOutput("rstY",          32'(y),           32'd0);
        checkOutput("rstVideoOn",    32'(video_on),    32'd0);
        checkOutput("rstPTick",      32'(p_tick),      32'd0);
        checkOutput("rstLineStart",  32'(line_start),  32'd0);
        checkOutput("rstFrameStart", 32'(frame_start), 32'd0);
        checkOutput("rstRunning",    32'(running),     32'd0);
        checkOutput("rstHsync",      32'(hsync),       32'd0);
        checkOutput("rstVsync",      32'(vsync),       32'd1);

        // First tick lands CLK_DIV cycles after release.
        reset = 1'b0;
        step();
        checkOutput("relPTick1", 32'(p_tick), 32'd0);
        step();
        checkOutput("relPTick2", 32'(p_tick), 32'd1);
        step();
        checkOutput("idleRunning",    32'(running),     32'd0);
        checkOutput("idleFrameStart", 32'(frame_start), 32'd0);
        checkOutput("idleX",          32'(x),           32'd0);

        // Enter RUN from IDLE: stays at (0,0) and pulses the strobes.
        enable = 1'b1;
        applyStimulus(cyc);
        checkOutput("entryX",          32'(x),           32'd0);
        checkOutput("entryY",          32'(y),           32'd0);
        checkOutput("entryFrameStart", 32'(frame_start), 32'd1);
        checkOutput("entryLineStart",  32'(line_start),  32'd1);
        checkOutput("entryRunning",    32'(running),     32'd1);
        checkOutput("entryVideoOn",    32'(video_on),    32'd1);
        step();
        checkOutput("entryFsClear", 32'(frame_start), 32'd0);
        checkOutput("entryLsClear", 32'(line_start),  32'd0);
        checkOutput("entryXHold",   32'(x),           32'd0);

        // One full frame, checking every pixel position.
        frameCycles = 1;
        videoTicks  = 0;
        ex = 0;
        ey = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(cyc);
            frameCycles += cyc;
            advanceModel();
            checkOutput("sweepX",  32'(x), 32'(ex));
            checkOutput("sweepY",  32'(y), 32'(ey));
            checkOutput("sweepHsync", 32'(hsync),
                        (ex >= 5 && ex <= 6) ? 32'd1 : 32'd0);
            checkOutput("sweepVsync", 32'(vsync), (ey == 3) ? 32'd0 : 32'd1);
            checkOutput("sweepVideoOn", 32'(video_on),
                        (ex < 4 && ey < 2) ? 32'd1 : 32'd0);
            checkOutput("sweepLineStart", 32'(line_start), (ex == 0) ? 32'd1 : 32'd0);
            checkOutput("sweepFrameStart", 32'(frame_start),
                        (ex == 0 && ey == 0) ? 32'd1 : 32'd0);
            if (video_on === 1'b1) videoTicks++;
        end
        checkOutput("frameCycles", 32'(frameCycles), 32'd120);
        checkOutput("videoTicks",  32'(videoTicks),  32'd8);

        // Drop enable at (3,1): frame drains to (0,0) then IDLE, no frame_start.
        for (int k = 1; k <= 11; k++) begin
            applyStimulus(cyc);
            advanceModel();
        end
        checkOutput("drainPosX", 32'(x), 32'd3);
        checkOutput("drainPosY", 32'(y), 32'd1);
        enable = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            applyStimulus(cyc);
            advanceModel();
            checkOutput("drainX", 32'(x), 32'(ex));
            checkOutput("drainRunning", 32'(running), (k < 29) ? 32'd1 : 32'd0);
        end
        checkOutput("drainEndY",          32'(y),           32'd0);
        checkOutput("drainEndFrameStart", 32'(frame_start), 32'd0);
        checkOutput("drainEndLineStart",  32'(line_start),  32'd0);
        checkOutput("drainEndVideoOn",    32'(video_on),    32'd0);
        checkOutput("drainEndHsync",      32'(hsync),       32'd0);
        checkOutput("drainEndVsync",      32'(vsync),       32'd1);
        applyStimulus(cyc);
        checkOutput("idleHoldX",       32'(x),       32'd0);
        checkOutput("idleHoldRunning", 32'(running), 32'd0);

        // Re-enable during DRAIN: seamless wrap back into RUN with frame_start.
        enable = 1'b1;
        applyStimulus(cyc);
        checkOutput("reEntryFrameStart", 32'(frame_start), 32'd1);
        ex = 0;
        ey = 0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(cyc);
            advanceModel();
        end
        enable = 1'b0;
        applyStimulus(cyc);
        advanceModel();
        checkOutput("dipX",       32'(x),       32'd6);
        checkOutput("dipRunning", 32'(running), 32'd1);
        enable = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            applyStimulus(cyc);
            advanceModel();
        end
        checkOutput("seamlessX",          32'(x),           32'd0);
        checkOutput("seamlessY",          32'(y),           32'd0);
        checkOutput("seamlessFrameStart", 32'(frame_start), 32'd1);
        checkOutput("seamlessRunning",    32'(running),     32'd1);
        applyStimulus(cyc);
        advanceModel();
        checkOutput("seamlessNextX", 32'(x), 32'd1);

        // Mid-frame reset at (2,1) clears everything without waiting for an edge.
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(cyc);
            advanceModel();
        end
        checkOutput("preRstX",       32'(x),        32'd2);
        checkOutput("preRstY",       32'(y),        32'd1);
        checkOutput("preRstVideoOn", 32'(video_on), 32'd1);
        step();
        step();
        checkOutput("preRstPTick", 32'(p_tick), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstX",        32'(x),        32'd0);
        checkOutput("midRstY",        32'(y),        32'd0);
        checkOutput("midRstVideoOn",  32'(video_on), 32'd0);
        checkOutput("midRstRunning",  32'(running),  32'd0);
        checkOutput("midRstPTick",    32'(p_tick),   32'd0);
        checkOutput("midRstHsync",    32'(hsync),    32'd0);
        checkOutput("midRstVsync",    32'(vsync),    32'd1);
        enable = 1'b0;
        step();
        reset = 1'b0;
        step();

`ifdef VTG_FRAME_COUNTER_EN
        // Frame counter: entry plus two wraps gives three frames.
        checkOutput("fcReset", 32'(frame_count), 32'd0);
        enable = 1'b1;
        applyStimulus(cyc);
        for (int k = 1; k <= 81; k++) begin
            applyStimulus(cyc);
        end
        checkOutput("fcThree", 32'(frame_count), 32'd3);
        force dut.r_frameCount = 16'hFFFF;
        step();
        release dut.r_frameCount;
        checkOutput("fcPreload", 32'(frame_count), 32'd65535);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(cyc);
        end
        checkOutput("fcWrap", 32'(frame_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator replacing the fixed 640x480 controller in the video path. It derives a pixel tick from `clk_100MHz` with a configurable divider and produces pixel coordinates, a display-enable, and sync pulses with configurable polarity. It also provides line-start and frame-start strobes and a run/stop handshake that only starts or stops on frame boundaries. Pixel generators downstream consume `x`, `y`, `video_on` and `p_tick`; the sync pins go straight to the VGA connector.

## Interface
- `CLK_DIV`, 4: `clk_100MHz` cycles per pixel; legal range 1..16.
- `HD`, 640: horizontal active pixels.
- `HF`, 16: horizontal front porch (after active, before sync).
- `HR`, 96: horizontal sync width.
- `HB`, 48: horizontal back porch (after sync).
- `VD`, 480: vertical active lines.
- `VF`, 10: vertical front porch.
- `VR`, 2: vertical sync width.
- `VB`, 33: vertical back porch.
- `HSYNC_POL`, 0: 1 = active-high hsync, 0 = active-low.
- `VSYNC_POL`, 0: 1 = active-high vsync, 0 = active-low.
- `CW`, 10: coordinate width; requires HD+HF+HR+HB ≤ 2^CW and VD+VF+VR+VB ≤ 2^CW.
- `clk_100MHz` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run request, level-sensitive.
- `running` out 1: high while state is RUN or DRAIN.
- `p_tick` out 1: one-cycle pixel strobe.
- `x` out CW: horizontal count, 0..HTOT-1.
- `y` out CW: vertical count, 0..VTOT-1.
- `video_on` out 1: high when x<HD and y<VD and state≠IDLE.
- `hsync` out 1: horizontal sync, polarity per HSYNC_POL.
- `vsync` out 1: vertical sync, polarity per VSYNC_POL.
- `line_start` out 1: one-cycle strobe on the update to x=0.
- `frame_start` out 1: one-cycle strobe on the update to x=0, y=0.

## Operation
- HTOT = HD+HF+HR+HB; VTOT = VD+VF+VR+VB.
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `p_tick` = (div_cnt == CLK_DIV-1). With CLK_DIV=1, `p_tick` is constantly high.
- FSM has three states: IDLE, RUN, DRAIN.
  - IDLE: x=y=0, divider free-running, all strobes low, syncs inactive, `video_on`=0. An IDLE tick with `enable`=1 → RUN; outputs remain at (0,0) and `frame_start` pulses on that tick.
  - RUN: on each `p_tick`, x increments; at x=HTOT-1, x→0 and y increments; at y=VTOT-1 with x=HTOT-1, y→0. `enable`=0 → DRAIN, with no change to counting.
  - DRAIN: counting continues. On the tick that wraps to (0,0): if `enable`=0 → IDLE, no `frame_start`; if `enable`=1 → RUN, with a normal `frame_start`.
- Sync active while HD+HF ≤ x < HD+HF+HR (hsync) and VD+VF ≤ y < VD+VF+VR (vsync). Inactive level is the inverse of the polarity parameter. Syncs are forced inactive in IDLE.
- All coordinate, sync and `video_on` outputs are registered and computed from next-state counts, so they change together with zero skew.

## Timing
- Reset values: div_cnt=0, state=IDLE, x=0, y=0, `video_on`=0, `p_tick`=0 (reset forces div_cnt=0, so for CLK_DIV>1 `p_tick` is 0 during reset), `line_start`=0, `frame_start`=0, `running`=0, `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL.
- x, y, syncs, `video_on` and strobes update on the clock edge at which `p_tick`=1 and hold for CLK_DIV cycles.
- `line_start` and `frame_start` are high for exactly one `clk_100MHz` cycle, the cycle following the updating edge.
- `enable` is sampled only on `p_tick` edges. A pulse shorter than one pixel period may be missed.
- Reset asserted mid-frame returns everything to reset values immediately. After release, the first `p_tick` occurs CLK_DIV cycles later.

## Configuration
- `VTG_FRAME_COUNTER_EN`
  - Defined: adds output `frame_count` [15:0], reset 0, which increments in the cycle `frame_start` is high and wraps 65535→0.
  - Undefined: the port and its logic are absent.

## Test plan
- Reset with defaults → all outputs at reset values; `hsync`=`vsync`=1 (active-low inactive); `p_tick` every 4th cycle after release.
- enable=1, defaults, run one frame → 800 ticks per line and 525 lines (1,680,000 clk cycles per frame). hsync low exactly at x=656..751, vsync low exactly at y=490..491. `video_on` asserted for 307,200 ticks.
- Drop enable at (x=100, y=200) → counting continues to (799,524), then IDLE at (0,0) with `running`=0, no `frame_start`. Raising enable before the wrap → seamless RUN with `frame_start`.
- Assert reset at (x=300, y=100) → immediate return to reset values; x=0 and y=0 on the same edge.
- CLK_DIV=1, HD=4, HF=1, HR=2, HB=1, VD=2, VF=1, VR=1, VB=1, HSYNC_POL=1 → `p_tick` constantly high, hsync high only at x=5..6, frame length 40 cycles.
- With `VTG_FRAME_COUNTER_EN`, run 3 frames → `frame_count`=3. Preload to 65535 via force, then run 1 frame → 0.
